// File: rtl/psum_deskew_collector.sv
// South-edge receiver: realigns skewed bottom-row psums into full rows and queues them in a FIFO.
// Build macro PSUM_COLLECT_RELU_EN clamps negative lanes to zero as rows are pushed.
module psum_deskew_collector #(
    parameter int COLS             = 4,
    parameter int DATA_WIDTH_ACCUM = 32,
    parameter int DEPTH            = 8,
    parameter int AF_MARGIN        = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic [COLS-1:0]                  col_valid_in,
    input  logic [COLS*DATA_WIDTH_ACCUM-1:0] col_psum_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [COLS*DATA_WIDTH_ACCUM-1:0] out_data,
    output logic                             almost_full,
    output logic [$clog2(DEPTH):0]           fifo_count,
    output logic                             skew_err,
    output logic                             ovf_err
);
    localparam int W  = DATA_WIDTH_ACCUM;
    localparam int RW = COLS * W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

    logic [COLS-1:0] aligned_v;
    logic [RW-1:0]   aligned_d;

    // Lane c gets COLS-c stages so every lane of a row emerges in the same cycle.
    for (genvar c = 0; c < COLS; c++) begin : g_lane
        localparam int STAGES = COLS - c;
        logic [STAGES-1:0] v_q;
        logic [W-1:0]      d_q [STAGES];

        // NOTE: sequential state is written with <= only, so every stage samples pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= '0;
                for (int s = 0; s < STAGES; s++) d_q[s] <= '0;
            end else if (clr) begin
                v_q <= '0;
                for (int s = 0; s < STAGES; s++) d_q[s] <= '0;
            end else begin
                v_q[0] <= col_valid_in[c];
                d_q[0] <= col_psum_in[c*W +: W];
                for (int s = 1; s < STAGES; s++) begin
                    v_q[s] <= v_q[s-1];
                    d_q[s] <= d_q[s-1];
                end
            end
        end

        assign aligned_v[c]         = v_q[STAGES-1];
        assign aligned_d[c*W +: W]  = d_q[STAGES-1];
    end

    logic [RW-1:0] push_row;
`ifdef PSUM_COLLECT_RELU_EN
    always_comb begin
        push_row = aligned_d;
        for (int c = 0; c < COLS; c++) begin
            if (aligned_d[c*W + W - 1]) push_row[c*W +: W] = '0;
        end
    end
`else
    assign push_row = aligned_d;
`endif

    logic [RW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          skew_q, skew_d, ovf_q, ovf_d;
    logic          row_all, row_mixed, pop, push;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        row_all   = &aligned_v;
        row_mixed = (|aligned_v) && !row_all;
        pop       = out_valid && out_ready;
        // A full FIFO still takes the row when the head leaves in the same cycle.
        push      = row_all && ((count_q < FULL_LVL) || pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        skew_d = skew_q | row_mixed;
        ovf_d  = ovf_q | (row_all && !push);
    end

    // NOTE: the row storage is reset too, because out_data must read as zero after rst/clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            skew_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            skew_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            skew_q   <= skew_d;
            ovf_q    <= ovf_d;
            if (push) mem_q[wr_ptr_q] <= push_row;
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_data    = mem_q[rd_ptr_q];
    assign almost_full = (count_q >= AF_LVL);
    assign fifo_count  = count_q;
    assign skew_err    = skew_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_psum_deskew_collector.sv
// Bench for psum_deskew_collector: directed scenarios plus random traffic against a queue-based model.
// Expected lane values follow the PSUM_COLLECT_RELU_EN build macro when it is defined.
`timescale 1ns/1ps
module tb_psum_deskew_collector;
    localparam int COLS      = 4;
    localparam int W         = 32;
    localparam int DEPTH     = 4;
    localparam int AF_MARGIN = 2;
    localparam int RW        = COLS * W;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int HN        = 64;

    typedef logic [RW-1:0] row_t;
    typedef logic [127:0]  val_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            clr = 1'b0;
    logic            out_ready = 1'b0;
    logic [COLS-1:0] col_valid_in = '0;
    row_t            col_psum_in = '0;
    logic            out_valid, almost_full, skew_err, ovf_err;
    row_t            out_data;
    logic [CW-1:0]   fifo_count;

    psum_deskew_collector #(
        .COLS(COLS), .DATA_WIDTH_ACCUM(W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .col_valid_in(col_valid_in), .col_psum_in(col_psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .almost_full(almost_full), .fifo_count(fifo_count),
        .skew_err(skew_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int flush_cyc = 0;

    // Reference state: input history per cycle, a queue of stored rows, sticky flags.
    logic [COLS-1:0] hv [HN];
    row_t            hd [HN];
    row_t            exp_q [$];
    bit              exp_skew = 1'b0;
    bit              exp_ovf  = 1'b0;

    row_t burst_q [$];
    int   lane_extra [COLS];

    task automatic chk(input string tag, input val_t obs, input val_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic row_t relu_row(input row_t r);
        relu_row = r;
`ifdef PSUM_COLLECT_RELU_EN
        for (int c = 0; c < COLS; c++)
            if (r[c*W + W - 1]) relu_row[c*W +: W] = '0;
`endif
    endfunction

    function automatic row_t fill_row(input int v);
        row_t r;
        for (int c = 0; c < COLS; c++) r[c*W +: W] = W'(v);
        return r;
    endfunction

    // Applies the collector's rules at one clock edge: lane c of the row event
    // is whatever column c presented COLS-c cycles earlier.
    task automatic model_edge();
        int   nv;
        int   src;
        row_t raw;
        bit   pop;
        hv[cyc % HN] = col_valid_in;
        hd[cyc % HN] = col_psum_in;
        if (rst || clr) begin
            exp_q.delete();
            exp_skew  = 1'b0;
            exp_ovf   = 1'b0;
            flush_cyc = cyc;
            return;
        end
        nv  = 0;
        raw = '0;
        for (int c = 0; c < COLS; c++) begin
            src = cyc - (COLS - c);
            if (src > flush_cyc && hv[src % HN][c]) begin
                nv++;
                raw[c*W +: W] = hd[src % HN][c*W +: W];
            end
        end
        pop = (exp_q.size() != 0) && out_ready;
        if (pop) void'(exp_q.pop_front());
        if (nv == COLS) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(relu_row(raw));
            else exp_ovf = 1'b1;
        end else if (nv != 0) begin
            exp_skew = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("out_valid", val_t'(out_valid), val_t'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("out_data", val_t'(out_data), val_t'(exp_q[0]));
        chk("fifo_count", val_t'(fifo_count), val_t'(exp_q.size()));
        chk("almost_full", val_t'(almost_full), val_t'(exp_q.size() >= DEPTH - AF_MARGIN));
        chk("skew_err", val_t'(skew_err), val_t'(exp_skew));
        chk("ovf_err", val_t'(ovf_err), val_t'(exp_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic set_ready(input int mode, input bit is_last);
        case (mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = is_last;
        endcase
    endtask

    // Launches burst_q back-to-back: row r lane c is presented r+c+lane_extra[c] cycles in.
    task automatic send_burst(input int rdy_mode);
        int n;
        int maxx;
        int last;
        int r;
        n    = burst_q.size();
        maxx = 0;
        for (int c = 0; c < COLS; c++) if (lane_extra[c] > maxx) maxx = lane_extra[c];
        last = n - 1 + COLS + maxx;
        for (int k = 0; k <= last; k++) begin
            col_valid_in = '0;
            col_psum_in  = '0;
            for (int c = 0; c < COLS; c++) begin
                r = k - c - lane_extra[c];
                if (r >= 0 && r < n) begin
                    col_valid_in[c]       = 1'b1;
                    col_psum_in[c*W +: W] = burst_q[r][c*W +: W];
                end
            end
            set_ready(rdy_mode, k == last);
            step();
        end
        col_valid_in = '0;
        col_psum_in  = '0;
    endtask

    task automatic idle(input int n, input int rdy_mode);
        for (int k = 0; k < n; k++) begin
            col_valid_in = '0;
            set_ready(rdy_mode, 1'b0);
            step();
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", val_t'(out_valid), '0);
        chk("rst_count", val_t'(fifo_count), '0);
        chk("rst_data", val_t'(out_data), '0);
        chk("rst_flags", val_t'({almost_full, skew_err, ovf_err}), '0);
        step();
        rst = 1'b0;
    endtask

    function automatic void clear_extra();
        for (int c = 0; c < COLS; c++) lane_extra[c] = 0;
    endfunction

    initial begin
        row_t exp_neg;
        int   n;
        row_t rr;

        #2;
        do_reset();

        // Single skewed row: lane c at relative cycle 5+c, visible only in cycle 10.
        out_ready = 1'b1;
        for (int r = 0; r < 15; r++) begin
            chk("single_vld", val_t'(out_valid), val_t'(r == 10));
            if (r == 10) chk("single_data", val_t'(out_data), val_t'({32'd13, 32'd12, 32'd11, 32'd10}));
            col_valid_in = '0;
            col_psum_in  = '0;
            for (int c = 0; c < COLS; c++) begin
                if (r == 5 + c) begin
                    col_valid_in[c]       = 1'b1;
                    col_psum_in[c*W +: W] = W'(10 + c);
                end
            end
            step();
        end

        // Fill and overflow with the consumer stalled, then drain in order.
        clear_extra();
        burst_q.delete();
        for (int k = 1; k <= 5; k++) burst_q.push_back(fill_row(k));
        send_burst(0);
        chk("fill_count", val_t'(fifo_count), val_t'(DEPTH));
        chk("fill_ovf", val_t'(ovf_err), val_t'(1));
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_order", val_t'(out_data), val_t'(fill_row(k)));
            step();
        end
        chk("drain_empty", val_t'(out_valid), '0);

        // Full FIFO takes a new row when the head pops in the same cycle.
        do_clr();
        burst_q.delete();
        for (int k = 1; k <= 4; k++) burst_q.push_back(fill_row(k));
        send_burst(0);
        burst_q.delete();
        burst_q.push_back(fill_row(5));
        send_burst(3);
        chk("fullpop_count", val_t'(fifo_count), val_t'(DEPTH));
        chk("fullpop_ovf", val_t'(ovf_err), '0);
        chk("fullpop_head", val_t'(out_data), val_t'(fill_row(2)));

        // Lane 2 one cycle late: no push, sticky skew error, then clr.
        do_clr();
        burst_q.delete();
        burst_q.push_back(fill_row(9));
        lane_extra[2] = 1;
        send_burst(1);
        clear_extra();
        chk("skew_flag", val_t'(skew_err), val_t'(1));
        chk("skew_nopush", val_t'(fifo_count), '0);
        do_clr();
        chk("clr_skew", val_t'(skew_err), '0);
        chk("clr_count", val_t'(fifo_count), '0);
        chk("clr_valid", val_t'(out_valid), '0);

        // Async reset while lanes 0..1 of a row are in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            col_valid_in          = '0;
            col_valid_in[k]       = 1'b1;
            col_psum_in           = '0;
            col_psum_in[k*W +: W] = W'(77);
            step();
        end
        col_valid_in = '0;
        do_reset();
        idle(8, 1);
        chk("rst_no_partial", val_t'(out_valid), '0);
        chk("rst_no_count", val_t'(fifo_count), '0);

        // Negative lanes: lanes 0..3 = {-5, 7, -1, 0}.
        burst_q.delete();
        burst_q.push_back({32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFB});
        send_burst(0);
`ifdef PSUM_COLLECT_RELU_EN
        exp_neg = {32'd0, 32'd0, 32'd7, 32'd0};
`else
        exp_neg = {32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFB};
`endif
        chk("neg_valid", val_t'(out_valid), val_t'(1));
        chk("neg_lanes", val_t'(out_data), val_t'(exp_neg));
        do_clr();

        // Random traffic: bursts, stalls, occasional late lanes and flushes.
        for (int it = 0; it < 40; it++) begin
            burst_q.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                for (int c = 0; c < COLS; c++) rr[c*W +: W] = W'($urandom());
                burst_q.push_back(rr);
            end
            clear_extra();
            if ($urandom_range(0, 5) == 0) lane_extra[$urandom_range(0, COLS - 1)] = 1;
            send_burst($urandom_range(0, 2));
            idle($urandom_range(0, 3), 2);
            if ($urandom_range(0, 7) == 0) do_clr();
        end
        clear_extra();
        idle(DEPTH + 2, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
